// File: rtl/drum_div_seq.sv
// Sequential DRUM-style approximate unsigned divider: K-bit reduced mantissas,
// 1-bit/cycle restoring division, exponent rescale with saturation.
module drum_div_seq #(
    parameter int WIDTH = 16,
    parameter int K     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             dbz
);
    localparam int SW = $clog2(WIDTH + 1);
    localparam int EW = SW + 2;
    localparam int QW = 2 * K;
    localparam int CW = $clog2(QW + 1);
    localparam int WW = WIDTH + QW;

    // Handshake: a request moves when start & in_ready, a result when out_valid & out_ready.
    typedef enum logic [2:0] {IDLE, NORM, DIV, FIN, OUT} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      a_r, b_r;
    logic [K-1:0]          nb_r;
    logic signed [EW-1:0]  e_r;
    logic                  zero_r;
    logic [K:0]            rem_r;
    logic [QW-1:0]         quo_r;
    logic [CW-1:0]         cnt_r;

    logic [K-1:0]          ma_c, nb_c;
    logic [SW-1:0]         sa_c, sb_c;
    logic signed [EW-1:0]  e_c;
    logic [K:0]            trial, diff;
    logic                  ge;
    logic [EW-1:0]         neg_e;
    logic [WW-1:0]         wide;
    logic [WIDTH-1:0]      q_c;

    // Keep the K bits below and including the leading one; force the kept LSB to 1.
    function automatic void reduce(input logic [WIDTH-1:0] x,
                                   output logic [K-1:0] m, output logic [SW-1:0] s);
        int k;
        k = 0;
        for (int i = 0; i < WIDTH; i++) if (x[i]) k = i;
        if (k >= K) begin
            s = SW'(k - K + 1);
            m = K'(x >> (k - K + 1)) | K'(1);
        end else begin
            s = '0;
            m = x[K-1:0];
        end
    endfunction

    always_comb begin
        ma_c = '0; sa_c = '0; nb_c = '0; sb_c = '0;
        reduce(a_r, ma_c, sa_c);
        reduce(b_r, nb_c, sb_c);
        e_c = EW'(sa_c) - EW'(sb_c) - EW'(K);
    end

    always_comb begin
        trial = {rem_r[K-1:0], quo_r[QW-1]};
        ge    = trial >= {1'b0, nb_r};
        diff  = trial - {1'b0, nb_r};
    end

    always_comb begin
        neg_e = -e_r;
        if (!e_r[EW-1]) wide = WW'(quo_r) << $unsigned(e_r);
        else            wide = WW'(quo_r) >> neg_e;
        q_c = (|wide[WW-1:WIDTH]) ? '1 : wide[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)     state_d = NORM;
            NORM:                state_d = (b_r == '0) ? FIN : DIV;
            DIV:  if (cnt_r == CW'(QW - 1)) state_d = FIN;
            FIN:                 state_d = OUT;
            OUT:  if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0; b_r <= '0; nb_r <= '0; e_r <= '0; zero_r <= 1'b0;
            rem_r <= '0; quo_r <= '0; cnt_r <= '0; q <= '0; dbz <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    a_r <= a;
                    b_r <= b;
                end
                NORM: begin
                    nb_r   <= nb_c;
                    e_r    <= e_c;
                    zero_r <= (b_r == '0);
                    rem_r  <= '0;
                    quo_r  <= {ma_c, {K{1'b0}}};
                    cnt_r  <= '0;
                end
                // quo_r shifts dividend bits out at the top and quotient bits in at the bottom.
                DIV: begin
                    rem_r <= ge ? diff : trial;
                    quo_r <= {quo_r[QW-2:0], ge};
                    cnt_r <= cnt_r + CW'(1);
                end
                FIN: begin
                    q   <= zero_r ? '1 : q_c;
                    dbz <= zero_r;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_drum_div_seq.sv
// Self-checking bench for drum_div_seq: directed cases plus randomized ops
// against an arithmetic reference model.
module tb_drum_div_seq;
    localparam int WIDTH = 16;
    localparam int K     = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             in_ready, out_valid, dbz;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] q;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] exp_q[$];

    drum_div_seq #(.WIDTH(WIDTH), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .dbz(dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reduce(input longint x, output longint m, output longint s);
        longint msb;
        msb = -1;
        for (int i = 0; i < WIDTH; i++) if ((x / (64'd1 << i)) % 2 == 1) msb = i;
        if (msb >= K) begin
            s = msb - K + 1;
            m = (x / (64'd1 << s)) | 1;
        end else begin
            s = 0;
            m = x;
        end
    endfunction

    function automatic longint model_q(input longint av, input longint bv);
        longint ma, sa, nb, sb, qm, e, v;
        if (bv == 0) return (64'd1 << WIDTH) - 1;
        model_reduce(av, ma, sa);
        model_reduce(bv, nb, sb);
        qm = (ma * (64'd1 << K)) / nb;
        e  = sa - sb - K;
        v  = (e >= 0) ? qm * (64'd1 << e) : qm / (64'd1 << (-e));
        if (v >= (64'd1 << WIDTH)) v = (64'd1 << WIDTH) - 1;
        return v;
    endfunction

    // Issue one op, measure latency, optionally stall the consumer while pulsing start.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input int hold, input string tag);
        int lat;
        logic [WIDTH-1:0] q_seen;
        exp_q.push_back(WIDTH'(model_q(av, bv)));
        check({tag, "_in_ready"}, in_ready, 1);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, (bv == 0) ? 2 : 2 * K + 2);
        check({tag, "_q"}, q, exp_q.pop_front());
        check({tag, "_dbz"}, dbz, (bv == 0) ? 1 : 0);
        check({tag, "_busy"}, in_ready, 0);
        q_seen = q;
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_q"}, q, q_seen);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, out_valid, 0);
        check({tag, "_drain_ready"}, in_ready, 1);
    endtask

    initial begin
        int seen;
        logic [WIDTH-1:0] ra, rb;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", q, 0);
        check("rst_dbz", dbz, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        check("model_100_7", model_q(100, 7), 14);
        check("model_5000_40", model_q(5000, 40), 124);
        run_op(16'd60, 16'd5, 0, "d60_5");
        check("d60_5_const", q, 12);
        run_op(16'd100, 16'd7, 0, "d100_7");
        run_op(16'd5000, 16'd40, 0, "d5000_40");
        run_op(16'hFFFF, 16'd1, 0, "dffff_1");
        run_op(16'd1000, 16'd3000, 0, "d1000_3000");
        run_op(16'd0, 16'd77, 0, "d0_77");
        run_op(16'd1234, 16'd0, 0, "dbz");
        run_op(16'd60, 16'd5, 0, "after_dbz");
        run_op(16'd100, 16'd7, 5, "stall");

        // Reset in the middle of the divide: no result may survive it.
        a = 16'd5000; b = 16'd40; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst_no_stale", seen, 0);
        run_op(16'd60, 16'd5, 0, "post_rst");

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1, 2, 3: rb = WIDTH'($urandom_range(1, 63));
                default: rb = WIDTH'($urandom);
            endcase
            ra = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 63)) : WIDTH'($urandom);
            run_op(ra, rb, $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
